// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_pkg
//  Purpose  : Shared TAP state encoding, opcodes and FSM helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    localparam int IR_WIDTH     = 4;
    localparam int IDCODE_WIDTH = 32;

    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PAU_IR = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_e;

    // Aliases consumed by bypass_register
    localparam logic [3:0] CAPTURE_DR = 4'h6;
    localparam logic [3:0] SHIFT_DR   = 4'h2;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = 4'b0000;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = 4'b0001;
    localparam logic [IR_WIDTH-1:0] OP_USER   = 4'b0010;
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = 4'b1111;
    localparam logic [IR_WIDTH-1:0] BYPASS    = OP_BYPASS;

    function automatic tap_state_e tap_next(input tap_state_e st, input logic tms);
        tap_state_e nxt;
        nxt = TAP_TLR;
        case (st)
            TAP_TLR:    nxt = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: nxt = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: nxt = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: nxt = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: nxt = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: nxt = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
            default:    nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

    // Unimplemented opcodes collapse to BYPASS so the bypass path is always valid
    function automatic logic [IR_WIDTH-1:0] ir_map(input logic [IR_WIDTH-1:0] raw);
        logic [IR_WIDTH-1:0] op;
        case (raw)
            OP_EXTEST, OP_IDCODE, OP_USER: op = raw;
            default:                       op = OP_BYPASS;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_idcode_register.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_idcode_register
//  Purpose  : 32-bit IDCODE data register, capture/shift LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_idcode_register
    import jtag_pkg::*;
#(
    parameter logic [IDCODE_WIDTH-1:0] IDCODE_VALUE = 32'h1A2B_3C4D
) (
    input  logic TCK,
    input  logic TRST,
    input  logic i_capture,
    input  logic i_shift,
    input  logic i_tdi,
    output logic o_tdo
);

    logic [IDCODE_WIDTH-1:0] id_sr_q;
    logic [IDCODE_WIDTH-1:0] id_sr_d;

    always_comb begin
        id_sr_d = id_sr_q;
        if (i_capture) begin
            id_sr_d = IDCODE_VALUE;
        end else if (i_shift) begin
            id_sr_d = {i_tdi, id_sr_q[IDCODE_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            id_sr_q <= IDCODE_VALUE;
        end else begin
            id_sr_q <= id_sr_d;
        end
    end

    assign o_tdo = id_sr_q[0];

endmodule
`default_nettype wire

// File: rtl/jtag_tap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_tap_controller
//  Purpose  : 1149.1 TAP FSM, 4-bit IR, IDCODE DR and negedge TDO mux.
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter logic [IDCODE_WIDTH-1:0] IDCODE_VALUE = 32'h1A2B_3C4D
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bypass_tdo,
    input  logic                user_tdo,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] IR,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                TDO,
    output logic                TDO_EN
);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;
    logic                w_id_tdo;
    logic                w_id_capture;
    logic                w_id_shift;

    always_comb begin
        state_d = tap_next(state_q, TMS);

        ir_sr_d = ir_sr_q;
        if (state_q == TAP_CAP_IR) begin
            ir_sr_d = 4'b0101;
        end else if (state_q == TAP_SH_IR) begin
            ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        end

        // Entering or holding Test-Logic-Reset forces IDCODE, like TRST
        ir_d = ir_q;
        if (state_d == TAP_TLR) begin
            ir_d = OP_IDCODE;
        end else if (state_q == TAP_UPD_IR) begin
            ir_d = ir_map(ir_sr_q);
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q <= TAP_TLR;
            ir_q    <= OP_IDCODE;
            ir_sr_q <= 4'b0101;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
        end
    end

    assign w_id_capture = (state_q == TAP_CAP_DR) && (ir_q == OP_IDCODE);
    assign w_id_shift   = (state_q == TAP_SH_DR)  && (ir_q == OP_IDCODE);

    jtag_idcode_register #(
        .IDCODE_VALUE (IDCODE_VALUE)
    ) u_idcode (
        .TCK       (TCK),
        .TRST      (TRST),
        .i_capture (w_id_capture),
        .i_shift   (w_id_shift),
        .i_tdi     (TDI),
        .o_tdo     (w_id_tdo)
    );

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state_q == TAP_SH_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == TAP_SH_DR) begin
            tdo_en_d = 1'b1;
            case (ir_q)
                OP_IDCODE:         tdo_d = w_id_tdo;
                OP_EXTEST, OP_USER: tdo_d = user_tdo;
                default:           tdo_d = bypass_tdo;
            endcase
        end
    end

    // TDO launches on the falling edge so the receiver samples mid-bit
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign tap_state  = state_q;
    assign IR         = ir_q;
    assign capture_dr = (state_q == TAP_CAP_DR);
    assign shift_dr   = (state_q == TAP_SH_DR);
    assign update_dr  = (state_q == TAP_UPD_DR);
    assign TDO        = tdo_q;
    assign TDO_EN     = tdo_en_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_tap_controller
//  Purpose  : Directed self-checking bench for jtag_tap_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_controller;

    logic        TCK = 1'b0;
    logic        TRST = 1'b1;
    logic        TMS = 1'b0;
    logic        TDI = 1'b0;
    logic        user_tdo = 1'b0;
    logic        bypass_tdo;
    logic [3:0]  tap_state;
    logic [3:0]  IR;
    logic        capture_dr, shift_dr, update_dr;
    logic        TDO, TDO_EN;

    logic [31:0] c_id = 32'h1A2B_3C4D;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        byp_q;

    jtag_tap_controller #(
        .IDCODE_VALUE (32'h1A2B_3C4D)
    ) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .bypass_tdo (bypass_tdo),
        .user_tdo   (user_tdo),
        .tap_state  (tap_state),
        .IR         (IR),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .TDO        (TDO),
        .TDO_EN     (TDO_EN)
    );

    always #5 TCK = ~TCK;

    // Minimal one-bit bypass_register attached downstream
    always @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            byp_q <= 1'b0;
        end else if (IR == 4'hF) begin
            if (capture_dr)    byp_q <= 1'b0;
            else if (shift_dr) byp_q <= TDI;
        end
    end
    assign bypass_tdo = byp_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    // From RTI: shift v LSB first into IR, return to RTI
    task automatic load_ir(input logic [3:0] v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        #12;
        chk("rst_state", {28'd0, tap_state}, 32'hF);
        chk("rst_ir", {28'd0, IR}, 32'h1);
        chk("rst_tdo_en", {31'd0, TDO_EN}, 32'h0);
        chk("rst_tdo", {31'd0, TDO}, 32'h0);
        TRST = 1'b0;
        @(negedge TCK);
        #1;

        // IDCODE read
        tick(1'b0, 1'b0);
        chk("rti", {28'd0, tap_state}, 32'hC);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("cap_dr_state", {28'd0, tap_state}, 32'h6);
        chk("capture_dr", {31'd0, capture_dr}, 32'h1);
        tick(1'b0, 1'b0);
        chk("sh_dr_state", {28'd0, tap_state}, 32'h2);
        chk("shift_dr", {31'd0, shift_dr}, 32'h1);
        chk("id_tdo_en", {31'd0, TDO_EN}, 32'h1);
        chk("id_bit", {31'd0, TDO}, {31'd0, c_id[0]});
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 1'b0);
            chk("id_bit", {31'd0, TDO}, {31'd0, c_id[i]});
        end
        tick(1'b1, 1'b0);
        chk("ex1_dr_state", {28'd0, tap_state}, 32'h1);
        chk("ex1_tdo_en", {31'd0, TDO_EN}, 32'h0);
        chk("ex1_tdo", {31'd0, TDO}, 32'h0);
        tick(1'b1, 1'b0);
        chk("update_dr", {31'd0, update_dr}, 32'h1);
        tick(1'b0, 1'b0);

        // Load BYPASS by hand, watching the captured 0101
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("sel_ir_state", {28'd0, tap_state}, 32'h4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("sh_ir_state", {28'd0, tap_state}, 32'hA);
        chk("ir_cap_bit0", {31'd0, TDO}, 32'h1);
        tick(1'b0, 1'b1);
        chk("ir_cap_bit1", {31'd0, TDO}, 32'h0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("ex1_ir_state", {28'd0, tap_state}, 32'h9);
        chk("ir_before_upd", {28'd0, IR}, 32'h1);
        tick(1'b1, 1'b0);
        chk("upd_ir_state", {28'd0, tap_state}, 32'hD);
        tick(1'b0, 1'b0);
        chk("ir_bypass", {28'd0, IR}, 32'hF);

        // Bypass DR: TDI 1,0,1,1 -> TDO 0,1,0,1
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("byp_tdo0", {31'd0, TDO}, 32'h0);
        tick(1'b0, 1'b1);
        chk("byp_tdo1", {31'd0, TDO}, 32'h1);
        tick(1'b0, 1'b0);
        chk("byp_tdo2", {31'd0, TDO}, 32'h0);
        tick(1'b0, 1'b1);
        chk("byp_tdo3", {31'd0, TDO}, 32'h1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // USER routes user_tdo
        load_ir(4'b0010);
        chk("ir_user", {28'd0, IR}, 32'h2);
        user_tdo = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("user_tdo1", {31'd0, TDO}, 32'h1);
        user_tdo = 1'b0;
        tick(1'b0, 1'b0);
        chk("user_tdo0", {31'd0, TDO}, 32'h0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // EXTEST, then an unimplemented opcode
        load_ir(4'b0000);
        chk("ir_extest", {28'd0, IR}, 32'h0);
        load_ir(4'b0110);
        chk("ir_unimpl", {28'd0, IR}, 32'hF);

        // TMS reset from Pause-DR
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("pau_dr_state", {28'd0, tap_state}, 32'h3);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tms_rst_state", {28'd0, tap_state}, 32'hF);
        chk("tms_rst_ir", {28'd0, IR}, 32'h1);

        // Asynchronous TRST mid-shift in BYPASS
        tick(1'b0, 1'b0);
        load_ir(4'b1111);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("pre_trst_en", {31'd0, TDO_EN}, 32'h1);
        chk("pre_trst_tdo", {31'd0, TDO}, 32'h1);
        #1;
        TRST = 1'b1;
        #1;
        chk("trst_state", {28'd0, tap_state}, 32'hF);
        chk("trst_ir", {28'd0, IR}, 32'h1);
        chk("trst_tdo_en", {31'd0, TDO_EN}, 32'h0);
        chk("trst_tdo", {31'd0, TDO}, 32'h0);
        #10;
        TRST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1 TAP controller for the test access port: 16-state TAP FSM, 4-bit instruction register, built-in 32-bit IDCODE data register, and the registered TDO output mux. It sits directly upstream of `bypass_register` and the user data registers:
- It drives their `tap_state` and `IR` inputs.
- It consumes their serial outputs (`bypass_tdo`, `user_tdo`) to form the chip-level TDO.

## Interface
- `IDCODE_VALUE`, default 32'h1A2B_3C4D — value captured into the IDCODE DR; bit 0 must be 1.
- `TCK` input 1 — test clock; the only clock.
- `TRST` input 1 — asynchronous active-high reset.
- `TMS` input 1 — mode select, sampled on posedge TCK.
- `TDI` input 1 — serial data in, sampled on posedge TCK.
- `bypass_tdo` input 1 — serial out of `bypass_register`.
- `user_tdo` input 1 — serial out of the user/EXTEST data register.
- `tap_state` output 4 — current TAP state (standard 1149.1 encoding).
- `IR` output 4 — active instruction.
- `capture_dr`, `shift_dr`, `update_dr` output 1 each — decoded from `tap_state`.
- `TDO` output 1 — serial data out.
- `TDO_EN` output 1 — TDO driver enable.

## Operation
- **State encoding:**
  - TLR F, RTI C
  - DR column: SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5
  - IR column: SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D
- **FSM transitions:** standard 1149.1 graph; next state = f(state, TMS).
  - TLR: TMS=0 → RTI.
  - SEL_IR: TMS=1 → TLR.
  - UPD_xR: TMS=0 → RTI, TMS=1 → SEL_DR.
- **Opcodes:**
  - EXTEST 0000 → `user_tdo`
  - IDCODE 0001
  - USER 0010 → `user_tdo`
  - BYPASS 1111
  - Any other value written at Update-IR loads as 1111, so `bypass_register` is always active when the bypass path is selected.
- **IR shift register `ir_sr[3:0]`:**
  - CAP_IR: `ir_sr` ← 4'b0101.
  - SH_IR: `ir_sr` ← {TDI, `ir_sr`[3:1]} (LSB first).
  - UPD_IR: `IR` ← `ir_sr` (after the unimplemented→1111 mapping).
- **IDCODE DR `id_sr[31:0]`, only when `IR` == 0001:**
  - CAP_DR: `id_sr` ← `IDCODE_VALUE`.
  - SH_DR: `id_sr` ← {TDI, `id_sr`[31:1]}.
- **TDO mux source:**
  - SH_IR → `ir_sr`[0].
  - SH_DR → per `IR`: `id_sr`[0], `bypass_tdo`, or `user_tdo`.
  - Any other state → 0.
- **Reset values:**
  - `TRST` high: `tap_state` = F, `IR` = 0001, `ir_sr` = 0101, `id_sr` = `IDCODE_VALUE`, `TDO` = 0, `TDO_EN` = 0.
  - Entering TLR via TMS has the same effect on `IR` (→ 0001), synchronously.

## Timing
- `tap_state`, `IR`, `ir_sr`, `id_sr`: posedge TCK.
- `TDO`, `TDO_EN`: registered on negedge TCK from the mux and from (state == SH_IR or SH_DR); they change half a cycle after the state update.
- Decoded strobes: combinational from the `tap_state` register, so glitch-free and valid for the whole cycle.
- TMS=1 for 5 consecutive posedges reaches TLR from any state.
- Shift bit ordering:
  - First TDO bit of a shift = the bit captured in CAP_xR.
  - Bit k appears on TDO after the k-th SH posedge's following negedge.
  - The last bit is shifted out on the posedge that moves the FSM SH → EX1.
- `TRST` mid-operation: all regs reset immediately (asynchronous); `TDO_EN` drops without waiting for a clock edge. Deassertion is synchronised externally; no internal synchroniser.

## Structure
- Package `jtag_pkg`:
  - state localparams (shared with `bypass_register`, replacing its local CAPTURE_DR/SHIFT_DR/BYPASS);
  - opcode localparams;
  - IR width 4.
- Sub-module `jtag_idcode_register` (capture/shift of `id_sr`, parameter `IDCODE_VALUE`).
- FSM, IR, and TDO mux stay in `jtag_tap_controller`.

## Test plan
- **Reset:** `TRST` pulse → `tap_state` = F, `IR` = 0001, `TDO_EN` = 0.
- **IDCODE read:**
  - Stimulus: after reset, TMS 0,1,0,0 → SH_DR; shift 32 bits.
  - Required: TDO = `IDCODE_VALUE` LSB first (1,0,1,1,0,0,1,0,…); `TDO_EN` = 1 during the shift only.
- **Load BYPASS:**
  - Stimulus: shift IR 1111 via SH_IR, then UPD_IR.
  - Required:
    - the first two bits out of `ir_sr` are 1,0 (the 0101 capture);
    - `IR` becomes 1111 at the UPD_IR posedge;
    - with `bypass_register` attached, DR shift of TDI 1,0,1,1 → TDO 0,1,0,1 (one-bit delay).
- **Unimplemented opcode:** shift IR 0110 → after UPD_IR, `IR` = 1111.
- **TMS reset:** from PAU_DR, five TMS=1 → `tap_state` = F and `IR` = 0001, with no `TRST`.
- **Asynchronous reset mid-shift:** `TRST` asserted between edges in SH_DR → `tap_state` = F, `TDO_EN` = 0, `IR` = 0001 immediately; `TDO` = 0.
